// File: rtl/hvac_pkg.sv
// Shared HVAC types: plant FSM encoding and RGB indicator command codes.
// Used by the plant model and by the RGB indicator block.
package hvac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEAT    = 2'd1,
        ST_COOL    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        REQ_IDLE = 2'd0,
        REQ_HEAT = 2'd1,
        REQ_COOL = 2'd2
    } req_e;

    localparam logic [2:0] RGB_HEAT = 3'b100;
    localparam logic [2:0] RGB_IDLE = 3'b010;
    localparam logic [2:0] RGB_COOL = 3'b001;

    // Anything that is not exactly one of the two drive codes means idle.
    function automatic req_e decode_rgb(input logic [2:0] rgb);
        case (rgb)
            RGB_HEAT: return REQ_HEAT;
            RGB_COOL: return REQ_COOL;
            default:  return REQ_IDLE;
        endcase
    endfunction

    function automatic logic [7:0] step_temp(
        input logic [7:0] t,
        input logic       up,
        input logic [7:0] lo,
        input logic [7:0] hi
    );
        if (up) begin
            return (t >= hi) ? hi : t + 8'd1;
        end
        return (t <= lo) ? lo : t - 8'd1;
    endfunction

endpackage

// File: rtl/hvac_plant_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
// The tick is asserted while the count sits at DIV-1.
module tick_gen #(
    parameter int unsigned DIV = 100000000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hvac_plant.sv
// Simulated HVAC plant: heat/cool/lockout FSM driving a room temperature
// that moves one degree per tick, with minimum-run and lockout protection.
module hvac_plant
    import hvac_pkg::*;
#(
    parameter int unsigned TICK_DIV      = 100000000,
    parameter int unsigned MIN_RUN       = 3,
    parameter int unsigned LOCKOUT_TICKS = 5,
    parameter int unsigned TEMP_INIT     = 72,
    parameter int unsigned TEMP_MIN      = 32,
    parameter int unsigned TEMP_MAX      = 120
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] rgb_in,
    output logic [7:0] temp_out,
    output logic       heat_on,
    output logic       cool_on,
    output logic       fan_on,
    output logic       busy
);

    localparam int RW = (MIN_RUN > 0) ? $clog2(MIN_RUN + 1) : 1;
    localparam int LW = (LOCKOUT_TICKS > 0) ? $clog2(LOCKOUT_TICKS + 1) : 1;

    localparam logic [RW-1:0] RUN_MAX  = RW'(MIN_RUN);
    localparam logic [LW-1:0] LOCK_MAX = LW'(LOCKOUT_TICKS);
    localparam logic [7:0]    T_INIT   = 8'(TEMP_INIT);
    localparam logic [7:0]    T_MIN    = 8'(TEMP_MIN);
    localparam logic [7:0]    T_MAX    = 8'(TEMP_MAX);

    logic tick;

    tick_gen #(
        .DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    state_e        state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic [LW-1:0] lock_q, lock_d;
    logic [7:0]    temp_q, temp_d;
    logic          heat_on_q, heat_on_d;
    logic          cool_on_q, cool_on_d;
    logic          fan_on_q, fan_on_d;
    logic          busy_q, busy_d;

    req_e req;
    req_e mode_req;

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        lock_d   = lock_q;
        temp_d   = temp_q;
        req      = decode_rgb(rgb_in);
        mode_req = (state_q == ST_HEAT) ? REQ_HEAT : REQ_COOL;

        unique case (state_q)
            ST_IDLE: begin
                if (req == REQ_HEAT) begin
                    state_d = ST_HEAT;
                    run_d   = '0;
                end else if (req == REQ_COOL) begin
                    state_d = ST_COOL;
                    run_d   = '0;
                end
            end
            ST_HEAT, ST_COOL: begin
                // The temperature step lands even on the exit cycle.
                if (tick) begin
                    temp_d = step_temp(temp_q, state_q == ST_HEAT,
                                       T_MIN, T_MAX);
                    if (run_q < RUN_MAX) begin
                        run_d = run_q + 1'b1;
                    end
                end
                if (req != mode_req && run_q >= RUN_MAX) begin
                    state_d = ST_LOCKOUT;
                    lock_d  = '0;
                end
            end
            ST_LOCKOUT: begin
                if (lock_q >= LOCK_MAX) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    lock_d = lock_q + 1'b1;
                end
            end
        endcase

        heat_on_d = (state_d == ST_HEAT);
        cool_on_d = (state_d == ST_COOL);
        fan_on_d  = (state_d != ST_IDLE);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            run_q     <= '0;
            lock_q    <= '0;
            temp_q    <= T_INIT;
            heat_on_q <= 1'b0;
            cool_on_q <= 1'b0;
            fan_on_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            run_q     <= run_d;
            lock_q    <= lock_d;
            temp_q    <= temp_d;
            heat_on_q <= heat_on_d;
            cool_on_q <= cool_on_d;
            fan_on_q  <= fan_on_d;
            busy_q    <= busy_d;
        end
    end

    assign temp_out = temp_q;
    assign heat_on  = heat_on_q;
    assign cool_on  = cool_on_q;
    assign fan_on   = fan_on_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_hvac_plant.sv
// Bench for hvac_plant: three plants (start temps 72/118/33) share stimulus
// and are checked by directed scenarios and a tick-level reference model.
module tb_hvac_plant;
    import hvac_pkg::*;

    localparam int TD   = 4;
    localparam int MR   = 2;
    localparam int LT   = 3;
    localparam int TMIN = 32;
    localparam int TMAX = 120;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rgb_in;
    logic [7:0] temp_o [3];
    logic       heat_o [3];
    logic       cool_o [3];
    logic       fan_o  [3];
    logic       busy_o [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hvac_plant #(
            .TICK_DIV     (TD),
            .MIN_RUN      (MR),
            .LOCKOUT_TICKS(LT),
            .TEMP_INIT    ((g == 0) ? 72 : ((g == 1) ? 118 : 33)),
            .TEMP_MIN     (TMIN),
            .TEMP_MAX     (TMAX)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .rgb_in  (rgb_in),
            .temp_out(temp_o[g]),
            .heat_on (heat_o[g]),
            .cool_on (cool_o[g]),
            .fan_on  (fan_o[g]),
            .busy    (busy_o[g])
        );
    end

    // Reference model. Modes: 0 idle, 1 heating, 2 cooling, 3 lockout.
    int m_mode [3];
    int m_temp [3];
    int m_run  [3];
    int m_lock [3];
    int m_edges;

    function automatic int init_temp(input int i);
        return (i == 0) ? 72 : ((i == 1) ? 118 : 33);
    endfunction

    function automatic void model_reset();
        m_edges = 0;
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0;
            m_temp[i] = init_temp(i);
            m_run[i]  = 0;
            m_lock[i] = 0;
        end
    endfunction

    function automatic void model_step(input logic [2:0] rgb);
        bit tk;
        int want;
        int old_run;
        tk = ((m_edges % TD) == TD - 1);
        m_edges++;
        want = (rgb == 3'b100) ? 1 : ((rgb == 3'b001) ? 2 : 0);
        for (int i = 0; i < 3; i++) begin
            case (m_mode[i])
                0: if (want != 0) begin
                    m_mode[i] = want;
                    m_run[i]  = 0;
                end
                1, 2: begin
                    old_run = m_run[i];
                    if (tk) begin
                        if (m_mode[i] == 1)
                            m_temp[i] = (m_temp[i] + 1 > TMAX) ? TMAX : m_temp[i] + 1;
                        else
                            m_temp[i] = (m_temp[i] - 1 < TMIN) ? TMIN : m_temp[i] - 1;
                        m_run[i] = (m_run[i] + 1 > MR) ? MR : m_run[i] + 1;
                    end
                    if (want != m_mode[i] && old_run >= MR) begin
                        m_mode[i] = 3;
                        m_lock[i] = 0;
                    end
                end
                default: begin
                    if (m_lock[i] >= LT) m_mode[i] = 0;
                    else if (tk) m_lock[i]++;
                end
            endcase
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else model_step(rgb_in);
    end

    task automatic do_reset();
        rgb_in = RGB_IDLE;
        reset  = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rgb_in = RGB_HEAT;
        reset  = 1'b1;
        step(2);
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (temp_o[i] !== 8'(init_temp(i))) begin
                n_fail++;
                $display("FAIL reset_temp inst%0d: got %0d expected %0d",
                         i, temp_o[i], init_temp(i));
            end
            n_tests++;
            if ({heat_o[i], cool_o[i], fan_o[i], busy_o[i]} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_outs inst%0d: got %b expected 0000",
                         i, {heat_o[i], cool_o[i], fan_o[i], busy_o[i]});
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_heat();
        do_reset();
        rgb_in = RGB_HEAT;
        step(20);
        n_tests++;
        if (temp_o[0] !== 8'd77) begin
            n_fail++;
            $display("FAIL heat_temp: got %0d expected 77", temp_o[0]);
        end
        n_tests++;
        if ({heat_o[0], cool_o[0], fan_o[0], busy_o[0]} !== 4'b1011) begin
            n_fail++;
            $display("FAIL heat_outs: got %b expected 1011",
                     {heat_o[0], cool_o[0], fan_o[0], busy_o[0]});
        end
    endtask

    task automatic test_min_run();
        do_reset();
        rgb_in = RGB_HEAT;
        step(4);
        rgb_in = RGB_IDLE;
        step(4);
        n_tests++;
        if (heat_o[0] !== 1'b1 || temp_o[0] !== 8'd74) begin
            n_fail++;
            $display("FAIL minrun_hold: got heat=%b temp=%0d expected heat=1 temp=74",
                     heat_o[0], temp_o[0]);
        end
        step(1);
        n_tests++;
        if ({heat_o[0], cool_o[0], fan_o[0], busy_o[0]} !== 4'b0011) begin
            n_fail++;
            $display("FAIL minrun_lockout: got %b expected 0011",
                     {heat_o[0], cool_o[0], fan_o[0], busy_o[0]});
        end
        step(11);
        n_tests++;
        if (busy_o[0] !== 1'b1 || fan_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL minrun_lock_len: got busy=%b fan=%b expected 1 1",
                     busy_o[0], fan_o[0]);
        end
        step(1);
        n_tests++;
        if (busy_o[0] !== 1'b0 || fan_o[0] !== 1'b0 || temp_o[0] !== 8'd74) begin
            n_fail++;
            $display("FAIL minrun_idle: got busy=%b fan=%b temp=%0d expected 0 0 74",
                     busy_o[0], fan_o[0], temp_o[0]);
        end
    endtask

    task automatic test_reversal();
        int both;
        do_reset();
        rgb_in = RGB_COOL;
        step(8);
        n_tests++;
        if (cool_o[0] !== 1'b1 || temp_o[0] !== 8'd70) begin
            n_fail++;
            $display("FAIL rev_cool: got cool=%b temp=%0d expected 1 70",
                     cool_o[0], temp_o[0]);
        end
        rgb_in = RGB_HEAT;
        step(1);
        n_tests++;
        if ({heat_o[0], cool_o[0], fan_o[0]} !== 3'b001 || temp_o[0] !== 8'd70) begin
            n_fail++;
            $display("FAIL rev_lockout: got hcf=%b temp=%0d expected 001 70",
                     {heat_o[0], cool_o[0], fan_o[0]}, temp_o[0]);
        end
        both = 0;
        for (int c = 0; c < 12; c++) begin
            step(1);
            if (heat_o[0] && cool_o[0]) both++;
            if (c < 11 && (heat_o[0] || cool_o[0] || !fan_o[0])) both += 100;
        end
        n_tests++;
        if (both != 0 || busy_o[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL rev_lock_idle: got bad=%0d busy=%b expected 0 0",
                     both, busy_o[0]);
        end
        step(1);
        n_tests++;
        if ({heat_o[0], cool_o[0], fan_o[0]} !== 3'b101) begin
            n_fail++;
            $display("FAIL rev_heat: got hcf=%b expected 101",
                     {heat_o[0], cool_o[0], fan_o[0]});
        end
    endtask

    task automatic test_saturation();
        int exp_hi [5];
        exp_hi = '{119, 120, 120, 120, 120};
        do_reset();
        rgb_in = RGB_HEAT;
        for (int k = 0; k < 5; k++) begin
            step(4);
            n_tests++;
            if (temp_o[1] !== 8'(exp_hi[k])) begin
                n_fail++;
                $display("FAIL sat_hi tick%0d: got %0d expected %0d",
                         k, temp_o[1], exp_hi[k]);
            end
        end
        do_reset();
        rgb_in = RGB_COOL;
        for (int k = 0; k < 5; k++) begin
            step(4);
            n_tests++;
            if (temp_o[2] !== 8'd32 || temp_o[0] !== 8'(71 - k)) begin
                n_fail++;
                $display("FAIL sat_lo tick%0d: got %0d/%0d expected 32/%0d",
                         k, temp_o[2], temp_o[0], 71 - k);
            end
        end
    endtask

    task automatic test_reset_mid_heat();
        do_reset();
        rgb_in = RGB_HEAT;
        step(12);
        n_tests++;
        if (temp_o[0] !== 8'd75) begin
            n_fail++;
            $display("FAIL midheat_pre: got %0d expected 75", temp_o[0]);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({heat_o[0], cool_o[0], fan_o[0], busy_o[0]} !== 4'b0000 ||
            temp_o[0] !== 8'd72) begin
            n_fail++;
            $display("FAIL midheat_async: got outs=%b temp=%0d expected 0000 72",
                     {heat_o[0], cool_o[0], fan_o[0], busy_o[0]}, temp_o[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        step(3);
        n_tests++;
        if (temp_o[0] !== 8'd72 || heat_o[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL midheat_early: got temp=%0d heat=%b expected 72 1",
                     temp_o[0], heat_o[0]);
        end
        step(1);
        n_tests++;
        if (temp_o[0] !== 8'd73) begin
            n_fail++;
            $display("FAIL midheat_tick: got %0d expected 73", temp_o[0]);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] codes [4];
        codes = '{3'b111, 3'b000, 3'b110, 3'b011};
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rgb_in = codes[k];
            step(9);
            n_tests++;
            if (busy_o[0] !== 1'b0 || fan_o[0] !== 1'b0 || temp_o[0] !== 8'd72) begin
                n_fail++;
                $display("FAIL illegal rgb=%b: got busy=%b fan=%b temp=%0d expected 0 0 72",
                         codes[k], busy_o[0], fan_o[0], temp_o[0]);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        logic [4:0] got;
        logic [4:0] exp;
        hold = 0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                got = {temp_o[i][0], heat_o[i], cool_o[i], fan_o[i], busy_o[i]};
                exp = {1'b0, m_mode[i] == 1, m_mode[i] == 2,
                       m_mode[i] != 0, m_mode[i] != 0};
                n_tests++;
                if (temp_o[i] !== 8'(m_temp[i]) || got[3:0] !== exp[3:0] ||
                    (heat_o[i] && cool_o[i])) begin
                    n_fail++;
                    $display("FAIL random c%0d inst%0d: got temp=%0d hcfb=%b expected temp=%0d hcfb=%b",
                             c, i, temp_o[i], got[3:0], m_temp[i], exp[3:0]);
                end
            end
            if (hold == 0) begin
                case ($urandom_range(0, 5))
                    0, 1:    rgb_in = RGB_HEAT;
                    2, 3:    rgb_in = RGB_COOL;
                    4:       rgb_in = RGB_IDLE;
                    default: rgb_in = 3'($urandom);
                endcase
                hold = $urandom_range(1, 24);
            end
            hold--;
            reset = ($urandom_range(0, 199) == 0);
        end
        reset = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        rgb_in = RGB_IDLE;
        @(negedge clk);
        test_reset();
        test_heat();
        test_min_run();
        test_reversal();
        test_saturation();
        test_reset_mid_heat();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
